// File: rtl/decryption_dispatcher.sv
// Input stage of the decryption path: routes each message to one of three engines,
// truncates over-long messages with an injected token, and waits for the engine to drain.
module decryption_dispatcher #(
   parameter int                 D_WIDTH                = 8,
   parameter int                 MAX_NOF_CHARS          = 50,
   parameter logic [D_WIDTH-1:0] START_DECRYPTION_TOKEN = 8'hFA
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [D_WIDTH-1:0] data_i,
   input  logic               valid_i,
   input  logic [1:0]         sel_i,
   output logic               ready_o,
   output logic [D_WIDTH-1:0] data0_o,
   output logic [D_WIDTH-1:0] data1_o,
   output logic [D_WIDTH-1:0] data2_o,
   output logic               valid0_o,
   output logic               valid1_o,
   output logic               valid2_o,
   input  logic               busy0_i,
   input  logic               busy1_i,
   input  logic               busy2_i,
   output logic               err_o
);

   // state   | meaning
   // IDLE    | waiting for the first character of a message
   // FORWARD | streaming characters to the selected engine
   // INJECT  | message hit the limit, emit the token ourselves
   // DISCARD | dropping the truncated tail until the real token
   // WAIT_HI | waiting up to 4 cycles for engine busy to rise
   // WAIT_LO | waiting for engine busy to fall

   localparam int            CW      = $clog2(MAX_NOF_CHARS + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(MAX_NOF_CHARS);

   typedef enum logic [2:0] {IDLE, FORWARD, INJECT, DISCARD, WAIT_HI, WAIT_LO} state_t;

   state_t             state, state_nxt;
   logic [1:0]         sel_q, sel_nxt;
   logic [CW-1:0]      cnt, cnt_nxt, cnt_inc;
   logic [1:0]         wait_cnt, wait_nxt;
   logic               fwd_en;
   logic [1:0]         fwd_ch;
   logic [D_WIDTH-1:0] fwd_data;
   logic               err_nxt;
   logic               xfer, is_tok, busy_sel;
   logic [3:0]         busy_vec;
   logic [D_WIDTH-1:0] data_q [3];
   logic [2:0]         valid_q;
   logic               err_q;

   assign ready_o  = (state == IDLE) || (state == FORWARD) || (state == DISCARD);
   assign xfer     = valid_i && ready_o;
   assign is_tok   = (data_i == START_DECRYPTION_TOKEN);
   assign busy_vec = {1'b0, busy2_i, busy1_i, busy0_i};
   assign busy_sel = busy_vec[sel_q];
   assign cnt_inc  = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

   always_comb begin
      state_nxt = state;
      sel_nxt   = sel_q;
      cnt_nxt   = cnt;
      wait_nxt  = wait_cnt;
      fwd_en    = 1'b0;
      fwd_ch    = sel_q;
      fwd_data  = '0;
      err_nxt   = 1'b0;
      case (state)
         IDLE: begin
            if (xfer && !is_tok) begin
               if (sel_i == 2'd3) begin
                  err_nxt = 1'b1;
               end else begin
                  sel_nxt   = sel_i;
                  fwd_en    = 1'b1;
                  fwd_ch    = sel_i;
                  fwd_data  = data_i;
                  cnt_nxt   = CW'(1);
                  state_nxt = (MAX_NOF_CHARS == 1) ? INJECT : FORWARD;
               end
            end
         end
         FORWARD: begin
            if (xfer) begin
               fwd_en   = 1'b1;
               fwd_data = data_i;
               if (is_tok) begin
                  wait_nxt  = 2'd0;
                  state_nxt = WAIT_HI;
               end else begin
                  cnt_nxt = cnt_inc;
                  if (cnt_inc == CNT_MAX) state_nxt = INJECT;
               end
            end
         end
         INJECT: begin
            fwd_en    = 1'b1;
            fwd_data  = START_DECRYPTION_TOKEN;
            err_nxt   = 1'b1;
            state_nxt = DISCARD;
         end
         DISCARD: begin
            if (xfer && is_tok) begin
               wait_nxt  = 2'd0;
               state_nxt = WAIT_HI;
            end
         end
         WAIT_HI: begin
            // an engine that never raises busy must not lock up the input
            if (busy_sel)               state_nxt = WAIT_LO;
            else if (wait_cnt == 2'd3)  state_nxt = IDLE;
            else                        wait_nxt  = wait_cnt + 2'd1;
         end
         WAIT_LO: begin
            if (!busy_sel) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      if (state_nxt == IDLE && state != IDLE) cnt_nxt = '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         sel_q    <= 2'd0;
         cnt      <= '0;
         wait_cnt <= 2'd0;
         valid_q  <= 3'b000;
         err_q    <= 1'b0;
         for (int c = 0; c < 3; c++) data_q[c] <= '0;
      end else begin
         state    <= state_nxt;
         sel_q    <= sel_nxt;
         cnt      <= cnt_nxt;
         wait_cnt <= wait_nxt;
         err_q    <= err_nxt;
         for (int c = 0; c < 3; c++) begin
            valid_q[c] <= fwd_en && (fwd_ch == 2'(c));
            data_q[c]  <= (fwd_en && (fwd_ch == 2'(c))) ? fwd_data : '0;
         end
      end
   end

   assign data0_o  = data_q[0];
   assign data1_o  = data_q[1];
   assign data2_o  = data_q[2];
   assign valid0_o = valid_q[0];
   assign valid1_o = valid_q[1];
   assign valid2_o = valid_q[2];
   assign err_o    = err_q;

endmodule

// File: tb/tb_decryption_dispatcher.sv
// Bench for decryption_dispatcher: a default instance and a MAX_NOF_CHARS=4 instance share
// inputs; each is compared every cycle with a message-level reference model.
module tb_decryption_dispatcher;
   localparam logic [7:0] TOK = 8'hFA;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] data_i = 8'h00;
   logic       valid_i = 1'b0;
   logic [1:0] sel_i = 2'd0;
   logic       busy0 = 1'b0, busy1 = 1'b0, busy2 = 1'b0;

   logic       rdy [2];
   logic [7:0] dat [2][3];
   logic       vld [2][3];
   logic       err [2];

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   decryption_dispatcher dut (
      .clk(clk), .rst_n(rst_n), .data_i(data_i), .valid_i(valid_i), .sel_i(sel_i),
      .ready_o(rdy[0]),
      .data0_o(dat[0][0]), .data1_o(dat[0][1]), .data2_o(dat[0][2]),
      .valid0_o(vld[0][0]), .valid1_o(vld[0][1]), .valid2_o(vld[0][2]),
      .busy0_i(busy0), .busy1_i(busy1), .busy2_i(busy2), .err_o(err[0])
   );

   decryption_dispatcher #(.MAX_NOF_CHARS(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .data_i(data_i), .valid_i(valid_i), .sel_i(sel_i),
      .ready_o(rdy[1]),
      .data0_o(dat[1][0]), .data1_o(dat[1][1]), .data2_o(dat[1][2]),
      .valid0_o(vld[1][0]), .valid1_o(vld[1][1]), .valid2_o(vld[1][2]),
      .busy0_i(busy0), .busy1_i(busy1), .busy2_i(busy2), .err_o(err[1])
   );

   // reference model, one per instance, tracked as message phases
   bit         m_open [2];   // message accepted, more characters expected
   bit         m_inj  [2];   // limit reached, token still owed to the engine
   bit         m_disc [2];   // dropping the tail of a truncated message
   bit         m_drain[2];   // message handed over, waiting for the engine
   bit         m_seen [2];   // engine busy has been observed during drain
   int         m_cnt  [2];
   int         m_wait [2];
   int         m_ch   [2];
   int         m_max  [2] = '{50, 4};
   int         e_ch   [2];
   logic [7:0] e_dat  [2];
   bit         e_err  [2];

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_open[i] = 0; m_inj[i] = 0; m_disc[i] = 0; m_drain[i] = 0; m_seen[i] = 0;
         m_cnt[i] = 0; m_wait[i] = 0; m_ch[i] = 0;
         e_ch[i] = -1; e_dat[i] = 8'h00; e_err[i] = 0;
      end
   endtask

   function automatic bit m_ready(input int i);
      return !(m_inj[i] || m_drain[i]);
   endfunction

   task automatic model_step(input int i);
      logic b;
      bit   tok;
      e_ch[i] = -1; e_dat[i] = 8'h00; e_err[i] = 0;
      b   = (m_ch[i] == 0) ? busy0 : (m_ch[i] == 1) ? busy1 : busy2;
      tok = (data_i == TOK);
      if (m_drain[i]) begin
         if (!m_seen[i]) begin
            if (b) m_seen[i] = 1;
            else if (m_wait[i] == 3) m_drain[i] = 0;
            else m_wait[i]++;
         end else if (!b) begin
            m_drain[i] = 0;
         end
      end else if (m_inj[i]) begin
         e_ch[i] = m_ch[i]; e_dat[i] = TOK; e_err[i] = 1;
         m_inj[i] = 0; m_disc[i] = 1;
      end else if (valid_i) begin
         if (m_disc[i]) begin
            if (tok) begin m_disc[i] = 0; m_drain[i] = 1; m_wait[i] = 0; m_seen[i] = 0; end
         end else if (m_open[i]) begin
            e_ch[i] = m_ch[i]; e_dat[i] = data_i;
            if (tok) begin
               m_open[i] = 0; m_drain[i] = 1; m_wait[i] = 0; m_seen[i] = 0;
            end else begin
               m_cnt[i]++;
               if (m_cnt[i] == m_max[i]) begin m_open[i] = 0; m_inj[i] = 1; end
            end
         end else if (!tok) begin
            if (sel_i == 2'd3) begin
               e_err[i] = 1;
            end else begin
               m_ch[i] = int'(sel_i); e_ch[i] = m_ch[i]; e_dat[i] = data_i; m_cnt[i] = 1;
               if (m_cnt[i] == m_max[i]) m_inj[i] = 1; else m_open[i] = 1;
            end
         end
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs(input string where);
      for (int i = 0; i < 2; i++) begin
         for (int c = 0; c < 3; c++) begin
            chk($sformatf("%s u%0d valid%0d", where, i, c), 32'(vld[i][c]), 32'(e_ch[i] == c));
            chk($sformatf("%s u%0d data%0d", where, i, c), 32'(dat[i][c]),
                (e_ch[i] == c) ? 32'(e_dat[i]) : 32'h0);
         end
         chk($sformatf("%s u%0d err", where, i), 32'(err[i]), 32'(e_err[i]));
         chk($sformatf("%s u%0d ready", where, i), 32'(rdy[i]), 32'(m_ready(i)));
      end
   endtask

   task automatic tick(input string where);
      model_step(0);
      model_step(1);
      @(posedge clk);
      #1;
      check_outputs(where);
   endtask

   task automatic send(input logic [7:0] d, input logic [1:0] s, input string where);
      data_i = d; sel_i = s; valid_i = 1'b1;
      tick(where);
   endtask

   task automatic idle(input int n, input string where);
      valid_i = 1'b0;
      repeat (n) tick(where);
   endtask

   task automatic async_reset(input string where);
      #2 rst_n = 1'b0;
      valid_i = 1'b0;
      #1;
      model_reset();
      check_outputs(where);
      #2 rst_n = 1'b1;
   endtask

   initial begin
      model_reset();
      #2;
      check_outputs("reset");
      #6 rst_n = 1'b1;

      // routing to zigzag, then drain with a late busy pulse
      send(8'h41, 2'd2, "msg2"); send(8'h42, 2'd0, "msg2");
      send(8'h43, 2'd1, "msg2"); send(8'h44, 2'd2, "msg2");
      send(TOK, 2'd2, "msg2_tok");
      idle(1, "drain2");
      busy2 = 1'b1;
      repeat (4) tick("busy2");
      busy2 = 1'b0;
      idle(3, "release2");

      // illegal select, then a caesar message whose engine never goes busy
      send(8'h41, 2'd3, "bad_sel");
      send(8'h30, 2'd0, "msg0"); send(8'h31, 2'd3, "msg0");
      send(TOK, 2'd1, "msg0_tok");
      idle(6, "timeout0");

      // over-long scytale message truncated by the small instance
      for (int k = 0; k < 6; k++) send(8'h61 + 8'(k), 2'd1, "long1");
      send(TOK, 2'd1, "long1_tok");
      idle(7, "long1_drain");

      // empty message
      send(TOK, 2'd0, "empty");
      idle(1, "empty_after");

      // reset mid-message, then mid-WAIT_LO
      send(8'h51, 2'd0, "pre_rst"); send(8'h52, 2'd0, "pre_rst"); send(8'h53, 2'd0, "pre_rst");
      async_reset("rst_mid_msg");
      send(8'h5A, 2'd1, "post_rst"); send(TOK, 2'd0, "post_rst_tok");
      busy1 = 1'b1;
      idle(3, "wait_lo");
      async_reset("rst_wait_lo");
      busy1 = 1'b0;
      send(8'h71, 2'd2, "fresh"); send(TOK, 2'd2, "fresh_tok");
      idle(5, "fresh_drain");

      // randomized traffic with wandering busy lines
      for (int n = 0; n < 800; n++) begin
         valid_i = ($urandom % 4) != 0;
         data_i  = ($urandom % 7 == 0) ? TOK : 8'($urandom);
         sel_i   = 2'($urandom);
         if ($urandom % 4 == 0) busy0 = ~busy0;
         if ($urandom % 4 == 0) busy1 = ~busy1;
         if ($urandom % 4 == 0) busy2 = ~busy2;
         tick("random");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
